// File: rtl/eth_pcs_64_66_encoder_if.sv
// XGMII-side input and 66b-side output bundle of the 10G PCS TX encoder.
// The MAC/test side uses master; the encoder itself uses slave.
interface eth_pcs_64_66_encoder_if;
    logic [3:0]  i_xgmii_ctrl;
    logic [31:0] i_xgmii_data;
    logic        o_hdr_valid;
    logic [1:0]  o_hdr;
    logic [31:0] o_data;

    modport master (
        output i_xgmii_ctrl, i_xgmii_data,
        input  o_hdr_valid, o_hdr, o_data
    );

    modport slave (
        input  i_xgmii_ctrl, i_xgmii_data,
        output o_hdr_valid, o_hdr, o_data
    );
endinterface

// File: rtl/eth_pcs_64_66_encoder.sv
// 10G PCS transmit 64b/66b encoder: pairs XGMII transfers into blocks,
// classifies and encodes them, emits sync header plus two 32-bit slices.
module eth_pcs_64_66_encoder (
    input logic                    i_clk,
    input logic                    i_reset,
    input logic                    i_clk_en,
    eth_pcs_64_66_encoder_if.slave tx
);
    localparam int W_DATA     = 32;
    localparam int W_BYTE     = 8;
    localparam int N_CHANNELS = 4;
    localparam int W_BLK      = 64;
    localparam int W_SYNC     = 2;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    localparam logic [7:0] SYM_IDLE  = 8'h07;
    localparam logic [7:0] SYM_START = 8'hFB;
    localparam logic [7:0] SYM_TERM  = 8'hFD;
    localparam logic [7:0] SYM_ERR   = 8'hFE;

    localparam logic [6:0] CODE_IDLE = 7'h00;
    localparam logic [6:0] CODE_ERR  = 7'h1E;

    localparam logic [7:0] C_TYPE  = 8'h1E;
    localparam logic [7:0] S0_TYPE = 8'h78;
    localparam logic [7:0] S4_TYPE = 8'h33;
    // T0..T7 type bytes, T0 in the low byte
    localparam logic [63:0] T_TYPES = {
        8'hFF, 8'hE1, 8'hD2, 8'hCC, 8'hB4, 8'hAA, 8'h99, 8'h87
    };

    logic                  trans_cnt_q;
    logic [N_CHANNELS-1:0] buf_ctrl_q;
    logic [W_DATA-1:0]     buf_data_q;
    logic [W_DATA-1:0]     pay_hi_q;
    logic                  hdr_valid_q;
    logic [W_SYNC-1:0]     hdr_q;
    logic [W_DATA-1:0]     data_q;

    logic [7:0]        blk_ctrl;
    logic [W_BLK-1:0]  blk_data;
    logic [W_BYTE-1:0] lane [8];
    logic [7:0]        is_ic;
    logic [55:0]       codes;
    logic [W_SYNC-1:0] hdr_d;
    logic [W_BLK-1:0]  pay_d;

    assign blk_ctrl = {tx.i_xgmii_ctrl, buf_ctrl_q};
    assign blk_data = {tx.i_xgmii_data, buf_data_q};

    // Lane j's 7-bit code sits at codes[7j+:7], i.e. payload bit 8+7j
    always_comb begin
        codes = '0;
        is_ic = '0;
        for (int i = 0; i < 8; i++) begin
            lane[i]  = blk_data[8*i +: 8];
            is_ic[i] = blk_ctrl[i] &&
                       (lane[i] == SYM_IDLE || lane[i] == SYM_ERR);
            codes[7*i +: 7] = (lane[i] == SYM_ERR) ? CODE_ERR : CODE_IDLE;
        end
    end

    always_comb begin
        logic [7:0]       hi_mask;
        logic [W_BLK-1:0] t_pay;
        logic             t_hit;
        hdr_d   = SYNC_CTRL;
        pay_d   = {{8{CODE_ERR}}, C_TYPE};
        hi_mask = '0;
        t_pay   = '0;
        t_hit   = 1'b0;
        if (blk_ctrl == 8'h00) begin
            hdr_d = SYNC_DATA;
            pay_d = blk_data;
        end else if (blk_ctrl == 8'hFF && &is_ic) begin
            pay_d = {codes, C_TYPE};
        end else if (blk_ctrl == 8'h01 && lane[0] == SYM_START) begin
            pay_d = {blk_data[63:8], S0_TYPE};
        end else if (blk_ctrl == 8'h1F && &is_ic[3:0] &&
                     lane[4] == SYM_START) begin
            pay_d = {blk_data[63:40], 4'b0000, codes[27:0], S4_TYPE};
        end else begin
            for (int k = 0; k < 8; k++) begin
                hi_mask = 8'hFE << k;
                if (!t_hit && blk_ctrl == (8'hFF << k) &&
                    lane[k] == SYM_TERM && &(is_ic | ~hi_mask)) begin
                    t_hit = 1'b1;
                    t_pay = '0;
                    t_pay[7:0] = T_TYPES[8*k +: 8];
                    for (int i = 0; i < 7; i++)
                        if (i < k) t_pay[8*i+8 +: 8] = lane[i];
                    for (int j = 1; j < 8; j++)
                        if (j > k) t_pay[8+7*j +: 7] = codes[7*j +: 7];
                end
            end
            if (t_hit) pay_d = t_pay;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            trans_cnt_q <= 1'b0;
            buf_ctrl_q  <= '0;
            buf_data_q  <= '0;
            pay_hi_q    <= '0;
            hdr_valid_q <= 1'b0;
            hdr_q       <= SYNC_CTRL;
            data_q      <= '0;
        end else if (i_clk_en) begin
            trans_cnt_q <= ~trans_cnt_q;
            if (!trans_cnt_q) begin
                buf_ctrl_q  <= tx.i_xgmii_ctrl;
                buf_data_q  <= tx.i_xgmii_data;
                hdr_valid_q <= 1'b0;
                data_q      <= pay_hi_q;
            end else begin
                hdr_q       <= hdr_d;
                pay_hi_q    <= pay_d[63:32];
                data_q      <= pay_d[31:0];
                hdr_valid_q <= 1'b1;
            end
        end
    end

    assign tx.o_hdr_valid = hdr_valid_q;
    assign tx.o_hdr       = hdr_q;
    assign tx.o_data      = data_q;
endmodule
